// File: rtl/led_scan_capture.sv
`timescale 1ns/1ps
// led_scan_capture
//   Receiving end of the 16x16 red/green LED board scan interface. It samples
//   the 36-bit scan bus, rebuilds the frame row by row in a shadow buffer, and
//   publishes a complete frame only after all 16 rows have been seen in order.
//
// Ports
//   CLK        system clock
//   RST_N      reset, asynchronous assert, active-low
//   GPIO_1     scan bus: [35:32] row select, [31:16] green, [15:0] red
//              (column 0 at the MSB of each half)
//   Enable     capture enable; when low, no captures and the stability count holds
//   RedPixels  last complete red frame, [row][col]
//   GrnPixels  last complete green frame, [row][col]
//   FrameValid one-cycle pulse when RedPixels/GrnPixels update
//   FrameCount completed frames since reset (wraps)
//   SeqErr     one-cycle pulse on an out-of-order row capture
//   CurRow     row index of the most recent capture
module led_scan_capture #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [35:0]        GPIO_1,
  input  logic               Enable,
  output logic [15:0][15:0]  RedPixels,
  output logic [15:0][15:0]  GrnPixels,
  output logic               FrameValid,
  output logic [7:0]         FrameCount,
  output logic               SeqErr,
  output logic [3:0]         CurRow
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic [35:0] sync_reg [SYNC_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge CLK or negedge RST_N) begin
          if (!RST_N) sync_reg[gi] <= '0;
          else        sync_reg[gi] <= GPIO_1;
        end
      end else begin : g_rest
        always_ff @(posedge CLK or negedge RST_N) begin
          if (!RST_N) sync_reg[gi] <= '0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  logic [35:0] synced;
  logic [3:0]  row_sync;
  logic [15:0] red_row;
  logic [15:0] grn_row;

  assign synced   = sync_reg[SYNC_STAGES-1];
  assign row_sync = synced[35:32];

  // Bus carries column 0 at the MSB; pixel arrays are indexed by column.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_colmap
      assign red_row[gi] = synced[15-gi];
      assign grn_row[gi] = synced[31-gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Row-select stability counter
  // ---------------------------------------------------------------------------
  logic [3:0]    held_row_reg;
  logic [CW-1:0] count_reg;
  logic          capture;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      held_row_reg <= '0;
      count_reg    <= '0;
    end else if (row_sync != held_row_reg) begin
      // A new row restarts the dwell even while capture is disabled.
      held_row_reg <= row_sync;
      count_reg    <= '0;
    end else if (Enable && (count_reg < CW'(STABLE_CYCLES))) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Fires exactly once per dwell: on the step into saturation.
  assign capture = (row_sync == held_row_reg) && Enable &&
                   (count_reg == CW'(STABLE_CYCLES - 1));

  // ---------------------------------------------------------------------------
  // Sequence tracking
  // ---------------------------------------------------------------------------
  logic        locked_reg;
  logic [15:0] rows_seen_reg;
  logic [3:0]  expected_reg;
  logic [15:0] row_onehot;
  logic [15:0] rows_merged;
  logic        in_order;
  logic        frame_done;

  assign row_onehot  = 16'(1) << held_row_reg;
  assign rows_merged = rows_seen_reg | row_onehot;
  assign in_order    = locked_reg && (held_row_reg == expected_reg);
  // Only an in-order row 15 can complete a frame; a lock or a resync starts
  // rows_seen from a single bit, which can never be all ones.
  assign frame_done  = capture && in_order && (held_row_reg == 4'd15) && (&rows_merged);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      locked_reg    <= 1'b0;
      rows_seen_reg <= '0;
      expected_reg  <= '0;
      SeqErr        <= 1'b0;
      CurRow        <= '0;
      FrameValid    <= 1'b0;
      FrameCount    <= '0;
    end else begin
      SeqErr     <= 1'b0;
      FrameValid <= 1'b0;
      if (capture) begin
        CurRow       <= held_row_reg;
        expected_reg <= held_row_reg + 4'd1;
        locked_reg   <= 1'b1;
        if (!locked_reg) begin
          rows_seen_reg <= row_onehot;
        end else if (in_order) begin
          rows_seen_reg <= frame_done ? 16'd0 : rows_merged;
        end else begin
          SeqErr        <= 1'b1;
          rows_seen_reg <= row_onehot;
        end
        if (frame_done) begin
          FrameValid <= 1'b1;
          FrameCount <= FrameCount + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow buffer and published frame
  // ---------------------------------------------------------------------------
  logic [15:0] shadow_red_reg [16];
  logic [15:0] shadow_grn_reg [16];
  logic [15:0] out_red_reg    [16];
  logic [15:0] out_grn_reg    [16];

  generate
    for (gi = 0; gi < 16; gi++) begin : g_rows
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          shadow_red_reg[gi] <= '0;
          shadow_grn_reg[gi] <= '0;
        end else if (capture && (held_row_reg == 4'(gi))) begin
          shadow_red_reg[gi] <= red_row;
          shadow_grn_reg[gi] <= grn_row;
        end
      end

      // Row 15 is being written to the shadow on the completing edge, so it is
      // taken straight from the bus; every other row comes from the shadow.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          out_red_reg[gi] <= '0;
          out_grn_reg[gi] <= '0;
        end else if (frame_done) begin
          if (gi == 15) begin
            out_red_reg[gi] <= red_row;
            out_grn_reg[gi] <= grn_row;
          end else begin
            out_red_reg[gi] <= shadow_red_reg[gi];
            out_grn_reg[gi] <= shadow_grn_reg[gi];
          end
        end
      end

      assign RedPixels[gi] = out_red_reg[gi];
      assign GrnPixels[gi] = out_grn_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_led_scan_capture.sv
`timescale 1ns/1ps
// tb_led_scan_capture
//   Scoreboard bench: stimulus pushes expected FrameValid/SeqErr events into a
//   queue; a negedge monitor pops and compares each event the DUT presents.
module tb_led_scan_capture;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [35:0]       GPIO_1 = '0;
  logic              Enable = 1'b0;
  logic [15:0][15:0] RedPixels;
  logic [15:0][15:0] GrnPixels;
  logic              FrameValid;
  logic [7:0]        FrameCount;
  logic              SeqErr;
  logic [3:0]        CurRow;

  led_scan_capture #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .GPIO_1(GPIO_1), .Enable(Enable),
    .RedPixels(RedPixels), .GrnPixels(GrnPixels), .FrameValid(FrameValid),
    .FrameCount(FrameCount), .SeqErr(SeqErr), .CurRow(CurRow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit                is_frame;
    logic [7:0]        cnt;
    logic [3:0]        row;
    logic [15:0][15:0] red;
    logic [15:0][15:0] grn;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;

  logic [15:0][15:0] exp_red;
  logic [15:0][15:0] exp_grn;

  // ---------------------------------------------------------------- monitor
  always @(negedge CLK) begin
    if (RST_N && (FrameValid || SeqErr)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got FrameValid=%0b SeqErr=%0b CurRow=%0d FrameCount=%0d, required no event",
                 FrameValid, SeqErr, CurRow, FrameCount);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_frame) begin
          if (!FrameValid || SeqErr || FrameCount !== mon_e.cnt ||
              RedPixels !== mon_e.red || GrnPixels !== mon_e.grn) begin
            errors++;
            $display("FAIL frame_event: got FV=%0b SE=%0b cnt=%0d red=%h grn=%h, required FV=1 SE=0 cnt=%0d red=%h grn=%h",
                     FrameValid, SeqErr, FrameCount, RedPixels, GrnPixels,
                     mon_e.cnt, mon_e.red, mon_e.grn);
          end else
            $display("frame event: cnt=%0d ok", FrameCount);
        end else begin
          if (!SeqErr || FrameValid || CurRow !== mon_e.row) begin
            errors++;
            $display("FAIL seqerr_event: got SE=%0b FV=%0b CurRow=%0d, required SE=1 FV=0 CurRow=%0d",
                     SeqErr, FrameValid, CurRow, mon_e.row);
          end else
            $display("seqerr event: row=%0d ok", CurRow);
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else
      $display("check %s: %0h ok", name, act);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_red"}, RedPixels, '0);
    chk({tag, "_grn"}, GrnPixels, '0);
    chk({tag, "_fv"}, 256'(FrameValid), '0);
    chk({tag, "_cnt"}, 256'(FrameCount), '0);
    chk({tag, "_seqerr"}, 256'(SeqErr), '0);
    chk({tag, "_currow"}, 256'(CurRow), '0);
  endtask

  task automatic do_reset();
    Enable = 1'b0;
    GPIO_1 = '0;
    RST_N  = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic drive_row(input logic [3:0] r, input logic [15:0] red,
                           input logic [15:0] grn, input int dwell);
    GPIO_1 = {r, grn, red};
    Enable = 1'b1;
    repeat (dwell) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] cnt, input logic [15:0][15:0] red,
                            input logic [15:0][15:0] grn);
    ev_t e;
    e.is_frame = 1'b1; e.cnt = cnt; e.row = 4'd15; e.red = red; e.grn = grn;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input logic [3:0] row);
    ev_t e;
    e.is_frame = 1'b0; e.cnt = '0; e.row = row; e.red = '0; e.grn = '0;
    exp_q.push_back(e);
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1 chk_all_zero("reset");
    do_reset();

    // In-order scan, red row r = bit r on the pins -> column 15-r
    for (int r = 0; r < 16; r++) exp_red[r] = 16'h8000 >> r;
    push_frame(8'd1, exp_red, '0);
    for (int r = 0; r < 16; r++) drive_row(4'(r), 16'h0001 << r, 16'h0000, 10);
    idle(12);
    chk("scan1_currow", 256'(CurRow), 256'd15);
    chk("scan1_count", 256'(FrameCount), 256'd1);

    // Column reversal on row 3
    exp_red = '0; exp_grn = '0;
    exp_red[3] = 16'h0001; exp_grn[3] = 16'h8000;
    push_frame(8'd2, exp_red, exp_grn);
    for (int r = 0; r < 16; r++)
      drive_row(4'(r), (r == 3) ? 16'h8000 : 16'h0000, (r == 3) ? 16'h0001 : 16'h0000, 8);
    idle(12);
    chk("rev_count", 256'(FrameCount), 256'd2);

    // Skipped row 5 -> SeqErr at the row 6 capture, no frame
    do_reset();
    push_seq(4'd6);
    for (int r = 0; r < 16; r++)
      if (r != 5) drive_row(4'(r), 16'hFFFF, 16'h0000, 8);
    idle(12);
    chk("skip_count", 256'(FrameCount), 256'd0);
    for (int r = 0; r < 16; r++) exp_grn[r] = 16'h8000 >> r;
    push_frame(8'd1, '0, exp_grn);
    for (int r = 0; r < 16; r++) drive_row(4'(r), 16'h0000, 16'h0001 << r, 8);
    idle(12);
    chk("resync_count", 256'(FrameCount), 256'd1);

    // Lock mid-scan at row 8: only the second row 15 completes a frame
    do_reset();
    for (int r = 0; r < 16; r++) begin exp_red[r] = 16'h8F00; exp_grn[r] = 16'h000C; end
    push_frame(8'd1, exp_red, exp_grn);
    for (int r = 8; r < 16; r++) drive_row(4'(r), 16'h00F1, 16'h3000, 7);
    idle(10);
    chk("midlock_nocount", 256'(FrameCount), 256'd0);
    for (int r = 0; r < 16; r++) drive_row(4'(r), 16'h00F1, 16'h3000, 7);
    idle(12);
    chk("midlock_count", 256'(FrameCount), 256'd1);

    // Short row 2 dwell is never captured
    drive_row(4'd2, 16'h0000, 16'h0000, 3);
    drive_row(4'd0, 16'h0000, 16'h0000, 4);
    chk("short_dwell_currow", 256'(CurRow), 256'd15);
    drive_row(4'd0, 16'h0000, 16'h0000, 6);
    chk("row0_currow", 256'(CurRow), 256'd0);
    // Row 1 pixels change after its capture; the early value is kept
    exp_red = '0; exp_grn = '0;
    exp_red[1] = 16'h8000;
    push_frame(8'd2, exp_red, exp_grn);
    drive_row(4'd1, 16'h0001, 16'h0000, 6);
    drive_row(4'd1, 16'hFFFF, 16'h0000, 6);
    for (int r = 2; r < 16; r++) drive_row(4'(r), 16'h0000, 16'h0000, 7);
    idle(12);
    chk("middwell_count", 256'(FrameCount), 256'd2);

    // 256 frames -> FrameCount wraps to 0
    do_reset();
    for (int f = 1; f <= 256; f++) begin
      push_frame(8'(f), '0, '0);
      for (int r = 0; r < 16; r++) drive_row(4'(r), 16'h0000, 16'h0000, 6);
    end
    idle(12);
    chk("wrap_count", 256'(FrameCount), 256'd0);

    // Frames 1..6 with all pixels lit, then reset partway through frame 7
    for (int f = 1; f <= 6; f++) begin
      push_frame(8'(f), {16{16'hFFFF}}, {16{16'hFFFF}});
      for (int r = 0; r < 16; r++) drive_row(4'(r), 16'hFFFF, 16'hFFFF, 6);
    end
    for (int r = 0; r < 7; r++) drive_row(4'(r), 16'hFFFF, 16'hFFFF, 6);
    drive_row(4'd7, 16'hFFFF, 16'hFFFF, 3);
    chk("prereset_count", 256'(FrameCount), 256'd6);
    RST_N = 1'b0;
    #1 chk_all_zero("midreset");
    do_reset();
    for (int r = 0; r < 16; r++) begin exp_red[r] = 16'h8F00; exp_grn[r] = 16'h000C; end
    push_frame(8'd1, exp_red, exp_grn);
    for (int r = 0; r < 16; r++) drive_row(4'(r), 16'h00F1, 16'h3000, 7);
    idle(12);
    chk("postreset_count", 256'(FrameCount), 256'd1);

    chk("pending_events", 256'(exp_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
